// File: rtl/scan_controller.sv
// Raster scan sequencer: launches the point generator for each pixel, maps its
// iteration count to a colour index and writes it to the framebuffer in raster order.
//   state  | meaning
//   IDLE   | waiting for frame_start
//   LAUNCH | pg_start pulse for the current pixel
//   WAIT   | waiting for pg_done, then capture colour
//   WRITE  | wr_en held until wr_ready
//   DONE   | frame_done pulse
module scan_controller #(
  parameter int H_RES          = 640,
  parameter int V_RES          = 480,
  parameter int HBI            = 32,
  parameter int max_iterations = 255,
  parameter int ADDR_W         = 19
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              frame_start,
  input  logic              frame_abort,
  output logic [11:0]       x,
  output logic [11:0]       y,
  output logic              pg_start,
  input  logic              pg_done,
  input  logic [HBI-1:0]    pg_iteration,
  output logic              wr_en,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              frame_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [11:0]    X_LAST   = 12'(H_RES - 1);
  localparam logic [11:0]    Y_LAST   = 12'(V_RES - 1);
  localparam logic [HBI-1:0] ITER_CAP = HBI'(max_iterations);
  localparam logic [HBI-1:0] ITER_SAT = HBI'(255);

  state_t     state, state_nx;
  logic       last_pixel;
  logic       accept;
  logic       capture;
  logic [7:0] colour;

  assign last_pixel = (x == X_LAST) && (y == Y_LAST);

  // Points that hit the cap are drawn black; counts above 255 saturate.
  always_comb begin
    if (pg_iteration >= ITER_CAP)     colour = 8'd0;
    else if (pg_iteration > ITER_SAT) colour = 8'hFF;
    else                              colour = pg_iteration[7:0];
  end

  always_comb begin
    state_nx   = state;
    accept     = 1'b0;
    capture    = 1'b0;
    pg_start   = 1'b0;
    wr_en      = 1'b0;
    frame_done = 1'b0;
    busy       = (state != S_IDLE);
    case (state)
      S_IDLE:   if (frame_start) state_nx = S_LAUNCH;
      S_LAUNCH: begin
        pg_start = 1'b1;
        state_nx = S_WAIT;
      end
      S_WAIT: if (pg_done) begin
        capture  = 1'b1;
        state_nx = S_WRITE;
      end
      S_WRITE: begin
        wr_en = 1'b1;
        if (wr_ready) begin
          accept   = 1'b1;
          state_nx = last_pixel ? S_DONE : S_LAUNCH;
        end
      end
      S_DONE: begin
        frame_done = 1'b1;
        state_nx   = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    // Abort wins over any handshake completing in the same cycle.
    if (frame_abort && (state != S_IDLE)) begin
      state_nx = S_IDLE;
      accept   = 1'b0;
      capture  = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state   <= S_IDLE;
      x       <= '0;
      y       <= '0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      state <= state_nx;
      if ((state == S_IDLE) && frame_start) begin
        x       <= '0;
        y       <= '0;
        wr_addr <= '0;
      end
      if (capture) wr_data <= colour;
      // wr_addr tracks y*H_RES + x by incrementing alongside the raster position.
      if (accept && !last_pixel) begin
        wr_addr <= wr_addr + ADDR_W'(1);
        if (x == X_LAST) begin
          x <= '0;
          y <= y + 12'd1;
        end else begin
          x <= x + 12'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_scan_controller.sv
// Bench for scan_controller: directed frames plus random traffic, all outputs
// compared every cycle against a pixel-index level model of the scan.
module tb_scan_controller;
  localparam int H    = 4;
  localparam int V    = 3;
  localparam int N    = H * V;
  localparam int MAXI = 300;
  localparam int AW   = 19;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          frame_start = 1'b0;
  logic          frame_abort = 1'b0;
  logic [11:0]   x, y;
  logic          pg_start;
  logic          pg_done = 1'b0;
  logic [31:0]   pg_iteration = 32'd0;
  logic          wr_en;
  logic          wr_ready = 1'b0;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          busy;
  logic          frame_done;

  int tests = 0;
  int fails = 0;

  // model of expected outputs
  int e_p = 0, e_col = 0;
  bit e_busy = 0, e_ps = 0, e_we = 0, e_fd = 0;

  // point generator model
  bit pg_prev_start = 0;
  int pg_cnt = 0;
  int fixed_lat = 0;

  scan_controller #(
    .H_RES(H), .V_RES(V), .HBI(32), .max_iterations(MAXI), .ADDR_W(AW)
  ) dut (
    .CLK(clk), .RST_N(rst_n), .frame_start(frame_start), .frame_abort(frame_abort),
    .x(x), .y(y), .pg_start(pg_start), .pg_done(pg_done), .pg_iteration(pg_iteration),
    .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic int colour(input int it);
    if (it >= MAXI) return 0;
    if (it > 255) return 255;
    return it;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // What the outputs must become after the coming edge, given this cycle's inputs.
  task automatic model_step();
    if (!rst_n) begin
      e_busy = 0; e_ps = 0; e_we = 0; e_fd = 0; e_p = 0; e_col = 0;
    end else if (e_busy && frame_abort) begin
      e_busy = 0; e_ps = 0; e_we = 0; e_fd = 0;
    end else if (!e_busy) begin
      if (frame_start) begin e_busy = 1; e_ps = 1; e_p = 0; end
    end else if (e_ps) begin
      e_ps = 0;
    end else if (e_fd) begin
      e_fd = 0; e_busy = 0;
    end else if (e_we) begin
      if (wr_ready) begin
        e_we = 0;
        if (e_p == N - 1) e_fd = 1;
        else begin e_p++; e_ps = 1; end
      end
    end else if (pg_done) begin
      e_we = 1; e_col = colour(int'(pg_iteration));
    end
  endtask

  task automatic compare_all();
    chk("x", 32'(x), 32'(e_p % H));
    chk("y", 32'(y), 32'(e_p / H));
    chk("wr_addr", 32'(wr_addr), 32'(e_p));
    chk("wr_data", 32'(wr_data), 32'(e_col));
    chk("pg_start", 32'(pg_start), 32'(e_ps));
    chk("wr_en", 32'(wr_en), 32'(e_we));
    chk("frame_done", 32'(frame_done), 32'(e_fd));
    chk("busy", 32'(busy), 32'(e_busy));
  endtask

  // Point generator: done clears on the edge that samples pg_start (so it is
  // still stale-high during the launch cycle), rises again after a latency.
  task automatic pg_step();
    if (pg_prev_start) begin
      pg_done = 1'b0;
      pg_cnt  = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 4));
    end else if (pg_cnt > 0) begin
      pg_cnt--;
      if (pg_cnt == 0) begin
        pg_done      = 1'b1;
        pg_iteration = $urandom_range(0, 400);
      end
    end
    pg_prev_start = pg_start;
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
    compare_all();
    pg_step();
  endtask

  task automatic run_frame(input int bp_pix, input int abort_pix, input int rst_pix,
                           output int nwr, output int nfd, output int bp_len);
    int bp_cnt;
    bit ended;
    nwr = 0; nfd = 0; bp_len = 0; bp_cnt = 0; ended = 0;
    rst_n = 1; frame_abort = 0; wr_ready = 1; frame_start = 1;
    tick();
    for (int i = 0; i < 400 && !ended; i++) begin
      rst_n = 1; frame_abort = 0; wr_ready = 1; frame_start = 0;
      if (frame_done) begin nfd++; ended = 1; end
      if (wr_en && wr_addr == bp_pix) begin
        bp_len++;
        if (bp_cnt < 5) begin wr_ready = 0; bp_cnt++; end
      end
      if (wr_en && wr_addr == abort_pix) begin frame_abort = 1; ended = 1; end
      if (busy && !pg_start && !wr_en && !frame_done && wr_addr == rst_pix) begin
        rst_n = 0; frame_start = 1; ended = 1;
      end
      if (wr_en && wr_ready && !frame_abort) begin
        chk("write_addr_order", 32'(wr_addr), 32'(nwr));
        nwr++;
      end
      tick();
    end
    if (!ended) begin
      tests++; fails++;
      $display("FAIL frame_timeout: got no end of frame, expected one within 400 cycles");
    end
  endtask

  initial begin
    int nwr, nfd, bpl;

    chk("model_colour_255", 32'(colour(255)), 32'd255);
    chk("model_colour_17", 32'(colour(17)), 32'd17);
    chk("model_colour_300", 32'(colour(300)), 32'd0);
    chk("model_colour_280", 32'(colour(280)), 32'd255);
    chk("model_colour_0", 32'(colour(0)), 32'd0);

    rst_n = 0;
    for (int i = 0; i < 3; i++) tick();
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_wr_en", 32'(wr_en), 32'd0);
    chk("reset_wr_data", 32'(wr_data), 32'd0);

    fixed_lat = 3;
    run_frame(-1, -1, -1, nwr, nfd, bpl);
    chk("full_writes", 32'(nwr), 32'd12);
    chk("full_frame_done", 32'(nfd), 32'd1);
    chk("busy_after_done", 32'(busy), 32'd0);

    fixed_lat = 0;
    run_frame(2, -1, -1, nwr, nfd, bpl);
    chk("bp_wr_en_len", 32'(bpl), 32'd6);
    chk("bp_writes", 32'(nwr), 32'd12);

    run_frame(-1, 5, -1, nwr, nfd, bpl);
    chk("abort_writes", 32'(nwr), 32'd5);
    chk("abort_frame_done", 32'(nfd), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_wr_en", 32'(wr_en), 32'd0);

    run_frame(-1, -1, -1, nwr, nfd, bpl);
    chk("restart_writes", 32'(nwr), 32'd12);

    run_frame(-1, -1, 6, nwr, nfd, bpl);
    chk("rst_writes", 32'(nwr), 32'd6);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_x", 32'(x), 32'd0);
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      rst_n       = ($urandom_range(0, 299) != 0);
      frame_start = ($urandom_range(0, 7) == 0);
      frame_abort = ($urandom_range(0, 99) == 0);
      wr_ready    = ($urandom_range(0, 3) != 0);
      tick();
    end

    rst_n = 1; frame_start = 0; frame_abort = 0; wr_ready = 1;
    for (int i = 0; i < 4; i++) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
